fpu_mc_sequencer: RTL and testbench
===================================

Name: fpu_mc_sequencer

Overview:
Parametrised control sequencer for multi-cycle FPU operations (div, sqrt, fused ops). It sits between the FPU issue stage and the arithmetic units. It drives the operand-input mux select and the operand-register enable, freezes operands while a multi-cycle unit runs, and latches the operation code. It also counts execution cycles, detects unit hangs via a timeout, and reports completion, abort and timeout events to the pipeline.

Parameters:
OP_W, 5, width of the op code
MC_MAP, 32'h0000_080C, one bit per op code; bit i = 1 means op i is multi-cycle (default: ops 2, 3, 11); width 2**OP_W
CNT_W, 6, width of the execution-cycle counter
TIMEOUT, 63, cycle count in BUSY that triggers a timeout; must be >= 1 and <= 2**CNT_W-1

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  pipeline requests or holds an FPU operation; must stay high until completion
op  input  OP_W  operation code, sampled in IDLE
done  input  1  selected unit result ready (may be combinational, same cycle as start)
kill  input  1  pipeline flush; aborts an in-flight operation
in_sel  output  1  1 = operand mux selects fresh pipeline operands, 0 = feedback/held path
reg_AB_en  output  1  operand register load enable
busy  output  1  multi-cycle operation in flight
op_q  output  OP_W  op code latched at issue
cycle_cnt  output  CNT_W  cycles spent in BUSY for the current or last operation
result_valid  output  1  one-cycle pulse: operation completed and accepted
abort_pulse  output  1  one-cycle registered pulse: in-flight operation aborted
timeout_err  output  1  sticky timeout flag

Behaviour:
- States: IDLE, BUSY, ERR. On reset: state = IDLE; op_q = 0; cycle_cnt = 0; abort_pulse = 0; timeout_err = 0.
- Reset takes priority over all other inputs, including mid-operation. The next cycle is IDLE with no pulses.
- in_sel, reg_AB_en, busy and result_valid decode combinationally from state and inputs. All other outputs are registered.
- IDLE: in_sel = 1, reg_AB_en = 1, busy = 0.
  - start & done (same cycle): single-cycle completion. result_valid = 1, stay IDLE, no op latch.
  - Else start & MC_MAP[op] & !kill: go to BUSY, op_q <= op, cycle_cnt <= 0.
  - Else (non-multi-cycle op, or no start): stay IDLE. result_valid = start & done only.
  - kill in IDLE: no effect other than blocking issue.
- BUSY: in_sel = 0, reg_AB_en = 0, busy = 1. cycle_cnt increments by 1 each cycle and saturates at 2**CNT_W-1. Changes on op are ignored; op_q is held. Priority, highest first:
  1. kill or !start: go to IDLE, abort_pulse <= 1 next cycle, result_valid = 0 even if done is high.
  2. done: result_valid = 1 this cycle, go to IDLE; cycle_cnt retains its final value.
  3. cycle_cnt == TIMEOUT-1 (this edge brings it to TIMEOUT): go to ERR, timeout_err <= 1.
- ERR: in_sel = 0, reg_AB_en = 0, busy = 1, result_valid = 0. Stays in ERR while start = 1 and kill = 0; a late done is ignored. Exits to IDLE when start = 0 or kill = 1, with no abort_pulse. timeout_err stays high until reset, or until the next issue from IDLE into BUSY, which clears it.
- abort_pulse is high for exactly one cycle; it is 0 otherwise.
- Back-to-back operations: the completing cycle returns to IDLE. A new issue needs start to be seen in IDLE, so a single-cycle op may complete in the cycle directly after a multi-cycle completion.

Test Plan:
- Reset: assert reset for 2 cycles with start = 1, op = 2 -> in_sel = 1, reg_AB_en = 1, busy = 0, op_q = 0, cycle_cnt = 0, timeout_err = 0.
- Single-cycle op: op = 0, start = 1, done = 1 in one cycle -> result_valid = 1 that cycle, state stays IDLE, busy = 0 next cycle.
- Multi-cycle op: op = 3, start held, done at the 5th BUSY cycle -> busy = 1 and in_sel = 0 for 5 cycles, op_q = 3, result_valid pulse on the done cycle, cycle_cnt = 4, IDLE next.
- Edge case: op = 11, start & done in the issue cycle -> no BUSY entry, result_valid = 1.
- Kill mid-op: op = 2, kill at BUSY cycle 3 with done = 1 -> result_valid = 0, abort_pulse = 1 the next cycle, IDLE.
- Timeout: TIMEOUT = 4, op = 2, start held, done = 0 -> ERR after 4 BUSY cycles, timeout_err = 1 and held. Drop start -> IDLE. Reissue op = 2 -> timeout_err = 0.

Source files
------------

// File: rtl/fpu_mc_sequencer.sv
// fpu_mc_sequencer
// Control sequencer for multi-cycle FPU operations (div, sqrt, fused ops).
// It sits between the FPU issue stage and the arithmetic units. It steers the
// operand mux and the operand-register enable, and it freezes the operands
// while a multi-cycle unit runs. It latches the op code at issue and counts
// the cycles spent executing. It flags a hung unit with a timeout and reports
// completion and abort events back to the pipeline.
//
// Handshake: start is a level request that the pipeline holds until the
// operation finishes. done is the unit's result-ready strobe and may be high
// in the issue cycle itself. An operation is accepted when result_valid is
// high. Dropping start or raising kill while an operation is in flight
// abandons it.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         operation request / hold
//   op            op code, sampled in IDLE
//   done          selected unit result ready
//   kill          pipeline flush
//   in_sel        1 = fresh pipeline operands, 0 = held/feedback path
//   reg_AB_en     operand register load enable
//   busy          multi-cycle operation in flight (also high in ERR)
//   op_q          op code latched at issue
//   cycle_cnt     cycles spent in BUSY for the current or last operation
//   result_valid  operation completed and accepted this cycle
//   abort_pulse   one-cycle registered pulse after an in-flight abort
//   timeout_err   sticky timeout flag, cleared by reset or the next issue
module fpu_mc_sequencer #(
  parameter int                  OP_W    = 5,
  parameter logic [2**OP_W-1:0]  MC_MAP  = 32'h0000_080C,
  parameter int                  CNT_W   = 6,
  parameter int                  TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             done,
  input  logic             kill,
  output logic             in_sel,
  output logic             reg_AB_en,
  output logic             busy,
  output logic [OP_W-1:0]  op_q,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             result_valid,
  output logic             abort_pulse,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Value seen in the last BUSY cycle before the timeout edge.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t state;
  logic   issue;
  logic   abort_req;

  // Combinational decode of the mux/enable/status outputs. The issue and
  // abort qualifiers are also shared with the sequential block below.
  always_comb begin
    in_sel       = 1'b0;
    reg_AB_en    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    issue        = 1'b0;
    abort_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        in_sel       = 1'b1;
        reg_AB_en    = 1'b1;
        // A same-cycle done is a single-cycle completion and takes
        // precedence over entering BUSY. kill only blocks issue.
        result_valid = start & done;
        issue        = start & ~done & MC_MAP[op] & ~kill;
      end
      ST_BUSY: begin
        busy         = 1'b1;
        abort_req    = kill | ~start;
        result_valid = ~abort_req & done;
      end
      ST_ERR: begin
        busy         = 1'b1;
      end
      default: begin
        busy         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      op_q        <= '0;
      cycle_cnt   <= '0;
      abort_pulse <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      abort_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state       <= ST_BUSY;
            op_q        <= op;
            cycle_cnt   <= '0;
            timeout_err <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (abort_req) begin
            state       <= ST_IDLE;
            abort_pulse <= 1'b1;
          end else if (done) begin
            // cycle_cnt keeps its final value for the pipeline to read.
            state <= ST_IDLE;
          end else begin
            if (cycle_cnt != CNT_MAX) begin
              cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (cycle_cnt == TO_LAST) begin
              state       <= ST_ERR;
              timeout_err <= 1'b1;
            end
          end
        end
        ST_ERR: begin
          // A late done is ignored; leaving ERR is not an abort.
          if (kill || !start) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mc_sequencer.sv
// Testbench for fpu_mc_sequencer. Two instances share all inputs: inst 0 uses
// the default parameters and inst 1 uses TIMEOUT = 4, so that timeouts can be
// reached quickly. Directed scenarios check the listed behaviours, then a
// randomized run compares both instances against a cycle-level reference model.
module tb_fpu_mc_sequencer;

  localparam int OP_W  = 5;
  localparam int CNT_W = 6;

  logic            clk;
  logic            reset;
  logic            start;
  logic [OP_W-1:0] op;
  logic            done;
  logic            kill;

  logic [1:0]       in_sel_v;
  logic [1:0]       reg_en_v;
  logic [1:0]       busy_v;
  logic [1:0]       rv_v;
  logic [1:0]       abort_v;
  logic [1:0]       to_v;
  logic [OP_W-1:0]  op_q_v [2];
  logic [CNT_W-1:0] cnt_v  [2];

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    done  = 1'b0;
    kill  = 1'b0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  fpu_mc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .done(done), .kill(kill),
    .in_sel(in_sel_v[0]), .reg_AB_en(reg_en_v[0]), .busy(busy_v[0]),
    .op_q(op_q_v[0]), .cycle_cnt(cnt_v[0]), .result_valid(rv_v[0]),
    .abort_pulse(abort_v[0]), .timeout_err(to_v[0])
  );

  fpu_mc_sequencer #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .start(start), .op(op), .done(done), .kill(kill),
    .in_sel(in_sel_v[1]), .reg_AB_en(reg_en_v[1]), .busy(busy_v[1]),
    .op_q(op_q_v[1]), .cycle_cnt(cnt_v[1]), .result_valid(rv_v[1]),
    .abort_pulse(abort_v[1]), .timeout_err(to_v[1])
  );

  // ---------------- reference model ----------------
  // Per instance: is an operation outstanding, has it timed out, how many
  // cycles has it run, what op was accepted, and the registered flags.
  bit m_act   [2];
  bit m_err   [2];
  bit m_to    [2];
  bit m_abort [2];
  int m_cnt   [2];
  int m_opq   [2];
  int lim     [2] = '{63, 4};

  function automatic bit is_mc(input int o);
    return (o == 2) || (o == 3) || (o == 11);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit ab = 1'b0;
      if (reset) begin
        m_act[i] = 0; m_err[i] = 0; m_to[i] = 0; m_cnt[i] = 0; m_opq[i] = 0;
      end else if (!m_act[i]) begin
        if (start && !done && is_mc(int'(op)) && !kill) begin
          m_act[i] = 1; m_opq[i] = int'(op); m_cnt[i] = 0; m_to[i] = 0;
        end
      end else if (!m_err[i]) begin
        if (kill || !start) begin
          m_act[i] = 0; ab = 1'b1;
        end else if (done) begin
          m_act[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] < 63) ? m_cnt[i] + 1 : 63;
          if (m_cnt[i] == lim[i]) begin
            m_err[i] = 1; m_to[i] = 1;
          end
        end
      end else if (!start || kill) begin
        m_act[i] = 0; m_err[i] = 0;
      end
      m_abort[i] = reset ? 1'b0 : ab;
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic drive(input bit s, input int o, input bit d, input bit k);
    start = s;
    op    = OP_W'(o);
    done  = d;
    kill  = k;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 2, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({in_sel_v[0], reg_en_v[0], busy_v[0], abort_v[0], to_v[0]} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=11000",
               {in_sel_v[0], reg_en_v[0], busy_v[0], abort_v[0], to_v[0]});
    end
    checks++;
    if (op_q_v[0] !== '0 || cnt_v[0] !== '0) begin
      failures++;
      $display("FAIL reset_regs op_q=%0d cnt=%0d exp=0/0", op_q_v[0], cnt_v[0]);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0);
    @(posedge clk);
  endtask

  task automatic test_single_cycle();
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    checks++;
    if (rv_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_rv rv=%b busy=%b exp=1/0", rv_v[0], busy_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || rv_v[0] !== 1'b0 || op_q_v[0] !== 5'd0) begin
      failures++;
      $display("FAIL single_after busy=%b rv=%b op_q=%0d exp=0/0/0",
               busy_v[0], rv_v[0], op_q_v[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_multi_cycle();
    @(negedge clk);
    drive(1, 3, 0, 0);
    #1;
    checks++;
    if (in_sel_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL multi_issue in_sel=%b busy=%b exp=1/0", in_sel_v[0], busy_v[0]);
    end
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1, int'($urandom_range(0, 31)), (k == 4), 0);
      #1;
      checks++;
      if ({busy_v[0], in_sel_v[0], reg_en_v[0], rv_v[0]} !== {3'b100, (k == 4)}) begin
        failures++;
        $display("FAIL multi_busy k=%0d got=%b exp=%b", k,
                 {busy_v[0], in_sel_v[0], reg_en_v[0], rv_v[0]}, {3'b100, (k == 4)});
      end
      checks++;
      if (op_q_v[0] !== 5'd3 || int'(cnt_v[0]) != k) begin
        failures++;
        $display("FAIL multi_regs k=%0d op_q=%0d cnt=%0d exp=3/%0d", k, op_q_v[0], cnt_v[0], k);
      end
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || cnt_v[0] !== 6'd4 || abort_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL multi_done busy=%b cnt=%0d abort=%b exp=0/4/0",
               busy_v[0], cnt_v[0], abort_v[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_issue_done();
    @(negedge clk);
    drive(1, 11, 1, 0);
    #1;
    checks++;
    if (rv_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL mc_same_cycle rv=%b busy=%b exp=1/0", rv_v[0], busy_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || op_q_v[0] !== 5'd3) begin
      failures++;
      $display("FAIL mc_same_cycle_after busy=%b op_q=%0d exp=0/3", busy_v[0], op_q_v[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_kill();
    @(negedge clk);
    drive(1, 2, 0, 0);
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    drive(1, 2, 1, 1);
    #1;
    checks++;
    if (rv_v[0] !== 1'b0 || busy_v[0] !== 1'b1 || cnt_v[0] !== 6'd2) begin
      failures++;
      $display("FAIL kill_cycle rv=%b busy=%b cnt=%0d exp=0/1/2", rv_v[0], busy_v[0], cnt_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if (abort_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL kill_abort abort=%b busy=%b exp=1/0", abort_v[0], busy_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (abort_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL kill_abort_once abort=%b exp=0", abort_v[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    drive(1, 2, 0, 0);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (busy_v[1] !== 1'b1 || int'(cnt_v[1]) != k || to_v[1] !== 1'b0) begin
        failures++;
        $display("FAIL to_busy k=%0d busy=%b cnt=%0d to=%b exp=1/%0d/0",
                 k, busy_v[1], cnt_v[1], to_v[1], k);
      end
      @(posedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 2, (k == 1), 0);
      #1;
      checks++;
      if ({busy_v[1], in_sel_v[1], rv_v[1], to_v[1]} !== 4'b1001 || cnt_v[1] !== 6'd4) begin
        failures++;
        $display("FAIL to_err k=%0d flags=%b cnt=%0d exp=1001/4",
                 k, {busy_v[1], in_sel_v[1], rv_v[1], to_v[1]}, cnt_v[1]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    drive(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy_v[1] !== 1'b0 || to_v[1] !== 1'b1 || abort_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL to_exit busy=%b to=%b abort=%b exp=0/1/0", busy_v[1], to_v[1], abort_v[1]);
    end
    drive(1, 2, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (busy_v[1] !== 1'b1 || to_v[1] !== 1'b0 || op_q_v[1] !== 5'd2) begin
      failures++;
      $display("FAIL to_reissue busy=%b to=%b op_q=%0d exp=1/0/2", busy_v[1], to_v[1], op_q_v[1]);
    end
    drive(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (abort_v[1] !== 1'b1 || busy_v[1] !== 1'b0) begin
      failures++;
      $display("FAIL to_drop_abort abort=%b busy=%b exp=1/0", abort_v[1], busy_v[1]);
    end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 3, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 3, 1, 0);
    #1;
    checks++;
    if (rv_v[0] !== 1'b1 || busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_mc_done rv=%b busy=%b exp=1/1", rv_v[0], busy_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    drive(1, 0, 1, 0);
    #1;
    checks++;
    if (rv_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || in_sel_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_single rv=%b busy=%b in_sel=%b exp=1/0/1", rv_v[0], busy_v[0], in_sel_v[0]);
    end
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0);
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || abort_v[0] !== 1'b0 || op_q_v[0] !== 5'd3) begin
      failures++;
      $display("FAIL b2b_after busy=%b abort=%b op_q=%0d exp=0/0/3", busy_v[0], abort_v[0], op_q_v[0]);
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int mc_ops [3] = '{2, 3, 11};
    // Start from a known state for both the DUTs and the model.
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    for (int cyc = 0; cyc < 1000; cyc++) begin
      bit [5:0] exp_flags;
      bit [5:0] got_flags;
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 99) < 90);
      op    = ($urandom_range(0, 1) == 0) ? OP_W'(mc_ops[$urandom_range(0, 2)])
                                          : OP_W'($urandom_range(0, 31));
      done  = ($urandom_range(0, 9) == 0);
      kill  = ($urandom_range(0, 29) == 0);
      #1;
      for (int i = 0; i < 2; i++) begin
        bit exp_rv;
        exp_rv = m_act[i] ? (!m_err[i] && start && !kill && done) : (start && done);
        exp_flags = {!m_act[i], !m_act[i], m_act[i], exp_rv, m_abort[i], m_to[i]};
        got_flags = {in_sel_v[i], reg_en_v[i], busy_v[i], rv_v[i], abort_v[i], to_v[i]};
        checks++;
        if (got_flags !== exp_flags) begin
          failures++;
          $display("FAIL rand_flags inst=%0d cyc=%0d got=%b exp=%b", i, cyc, got_flags, exp_flags);
        end
        checks++;
        if (int'(op_q_v[i]) != m_opq[i] || $isunknown(op_q_v[i])) begin
          failures++;
          $display("FAIL rand_op_q inst=%0d cyc=%0d got=%0d exp=%0d", i, cyc, op_q_v[i], m_opq[i]);
        end
        checks++;
        if (int'(cnt_v[i]) != m_cnt[i] || $isunknown(cnt_v[i])) begin
          failures++;
          $display("FAIL rand_cnt inst=%0d cyc=%0d got=%0d exp=%0d", i, cyc, cnt_v[i], m_cnt[i]);
        end
      end
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    reset = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_issue_done();
    test_kill();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
